// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - encodings and FSM state type shared by the execute stage
package exec_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_PASS = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_RSV  = 3'b011;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    localparam logic [1:0] BSEL_RS2  = 2'b00;
    localparam logic [1:0] BSEL_IMM  = 2'b01;
    localparam logic [1:0] BSEL_FOUR = 2'b10;
    localparam logic [1:0] BSEL_ZERO = 2'b11;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

endpackage

// File: rtl/exec_muldiv.sv
// rtl/exec_muldiv.sv - iterative RV32M multiplier/divider, one bit per cycle on magnitudes
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            special,
    output logic [XLEN-1:0] special_res,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf;
    logic [2*XLEN-1:0] acc, acc_next, prod;
    logic [XLEN-1:0]   divisor;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_p, neg_r;
    logic [XLEN:0]     mul_sum, shifted, diff;
    logic              div_ok;
    logic [XLEN-1:0]   quo, rmd;

    assign done = busy && (cnt == CW'(XLEN - 1));

    // operand signedness, magnitudes and the two divide corner cases resolved at accept
    always_comb begin
        a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed = op[2] ? ~op[0] : ~op[1];
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = op[2] && (b == '0);
        div_ovf  = op[2] && !op[0] && (a == MIN_INT) && (b == '1);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = op[1] ? a : '1;
        else          special_res = op[1] ? '0 : a;
    end

    // one shift-add or restoring-divide step, plus sign correction of the would-be final value
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        div_ok  = ~diff[XLEN];
        if (op_q[2]) acc_next = {div_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0], acc[XLEN-2:0], div_ok};
        else         acc_next = {mul_sum, acc[XLEN-1:1]};
        prod = neg_p ? -acc_next : acc_next;
        quo  = acc_next[XLEN-1:0];
        rmd  = acc_next[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                       res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              res = neg_p ? -quo : quo;
            default:                      res = neg_r ? -rmd : rmd;
        endcase
    end

    // operand load on start, then XLEN iterations; kill abandons the operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            op_q    <= MD_MUL;
            neg_p   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (kill) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, a_mag};
            divisor <= b_mag;
            op_q    <= op;
            neg_p   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
        end else if (busy) begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_unit_mc.sv
// rtl/exec_unit_mc.sv - multi-cycle execute stage; EXEC_MULDIV_EN builds the RV32M path
module exec_unit_mc
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic            alua_src,
    input  logic [1:0]      alub_src,
    input  logic [3:0]      alu_ctr,
    input  logic [2:0]      branch,
    input  logic            br_unsigned,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] next_pc,
    output logic            taken,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);

    state_t          state, next_state;
    logic            accept, load_single;
    logic [XLEN-1:0] op_a, op_b, alu_res, pc4, pc_imm, br_tgt, single_res;
    logic [SW-1:0]   shamt;
    logic            eq, lt, br_taken;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready && !flush;

`ifdef EXEC_MULDIV_EN
    logic            md_special, md_busy, md_done, start_md;
    logic [XLEN-1:0] md_special_res, md_res;

    exec_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .start       (start_md),
        .kill        (flush),
        .op          (md_op),
        .a           (rs1),
        .b           (rs2),
        .special     (md_special),
        .special_res (md_special_res),
        .busy        (md_busy),
        .done        (md_done),
        .res         (md_res)
    );

    assign illegal    = 1'b0;
    assign single_res = md_en ? md_special_res : alu_res;
`else
    logic unused_md;
    assign unused_md  = ^md_op;
    assign single_res = md_en ? '0 : alu_res;

    // M ops have no hardware in this build and are flagged instead
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         illegal <= 1'b0;
        else if (accept) illegal <= md_en;
    end
`endif

    // operand select and single-cycle ALU
    always_comb begin
        op_a = alua_src ? pc : rs1;
        case (alub_src)
            BSEL_RS2:  op_b = rs2;
            BSEL_IMM:  op_b = imm;
            BSEL_FOUR: op_b = XLEN'(4);
            default:   op_b = '0;
        endcase
        shamt = op_b[SW-1:0];
        case (alu_ctr)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_PASS: alu_res = op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:  alu_res = '0;
        endcase
    end

    // branch/jump target and redirect flag; conditional branches pick pc+imm or pc+4
    always_comb begin
        pc4      = pc + XLEN'(4);
        pc_imm   = pc + imm;
        eq       = (op_a == op_b);
        lt       = br_unsigned ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
        br_taken = 1'b0;
        case (branch)
            BR_JAL:  br_taken = 1'b1;
            BR_JALR: br_taken = 1'b1;
            BR_BEQ:  br_taken = eq;
            BR_BNE:  br_taken = ~eq;
            BR_BLT:  br_taken = lt;
            BR_BGE:  br_taken = ~lt;
            default: br_taken = 1'b0;
        endcase
        if (branch == BR_JALR) br_tgt = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
        else if (br_taken)     br_tgt = pc_imm;
        else                   br_tgt = pc4;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // next state; flush overrides everything including a same-cycle accept
    always_comb begin
        next_state  = state;
        load_single = 1'b0;
`ifdef EXEC_MULDIV_EN
        start_md    = 1'b0;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
`ifdef EXEC_MULDIV_EN
                    if (md_en && !md_special) begin
                        next_state = S_CALC;
                        start_md   = 1'b1;
                    end else
`endif
                    begin
                        next_state  = S_DONE;
                        load_single = 1'b1;
                    end
                end else if ((state == S_DONE) && out_ready) begin
                    next_state = S_IDLE;
                end
            end
`ifdef EXEC_MULDIV_EN
            S_CALC: begin
                if (md_done)       next_state = S_DONE;
                else if (!md_busy) next_state = S_IDLE;
            end
`endif
            default: next_state = S_IDLE;
        endcase
        if (flush) next_state = S_IDLE;
    end

    // registered outputs: next_pc/taken fixed at accept, result when it becomes known
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            next_pc <= '0;
            taken   <= 1'b0;
        end else if (accept) begin
            next_pc <= md_en ? pc4 : br_tgt;
            taken   <= md_en ? 1'b0 : br_taken;
            if (load_single) result <= single_res;
        end
`ifdef EXEC_MULDIV_EN
        else if ((state == S_CALC) && md_done && !flush) begin
            result <= md_res;
        end
`endif
    end

endmodule

// File: tb/tb_exec_unit_mc.sv
// tb/tb_exec_unit_mc.sv - directed self-checking bench for exec_unit_mc
module tb_exec_unit_mc;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic [XLEN-1:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0;
    logic            alua_src = 1'b0;
    logic [1:0]      alub_src = 2'b00;
    logic [3:0]      alu_ctr = 4'b0000;
    logic [2:0]      branch = 3'b000;
    logic            br_unsigned = 1'b0;
    logic            md_en = 1'b0;
    logic [2:0]      md_op = 3'b000;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result, next_pc;
    logic            taken, illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_unit_mc #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .alua_src(alua_src), .alub_src(alub_src),
        .alu_ctr(alu_ctr), .branch(branch), .br_unsigned(br_unsigned), .md_en(md_en),
        .md_op(md_op), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .next_pc(next_pc), .taken(taken), .illegal(illegal)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [XLEN-1:0] p, r1, r2, im, input logic asrc,
                          input logic [1:0] bsrc, input logic [3:0] ctr,
                          input logic [2:0] br, input logic bu);
        in_valid = 1'b1; md_en = 1'b0; md_op = 3'b000;
        pc = p; rs1 = r1; rs2 = r2; imm = im;
        alua_src = asrc; alub_src = bsrc; alu_ctr = ctr; branch = br; br_unsigned = bu;
    endtask

    task automatic md_drive(input logic [2:0] op, input logic [XLEN-1:0] a, b);
        in_valid = 1'b1; md_en = 1'b1; md_op = op;
        pc = 32'h200; rs1 = a; rs2 = b; imm = 32'h40;
        alua_src = 1'b0; alub_src = 2'b01; alu_ctr = 4'b0000; branch = 3'b001; br_unsigned = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [XLEN-1:0] r, npc, input logic tk);
        chk({tag, " out_valid"}, XLEN'(out_valid), 32'd1);
        chk({tag, " result"}, result, r);
        chk({tag, " next_pc"}, next_pc, npc);
        chk({tag, " taken"}, XLEN'(taken), XLEN'(tk));
        chk({tag, " illegal"}, XLEN'(illegal), 32'd0);
    endtask

    task automatic md_case(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a, b,
                           input logic [XLEN-1:0] exp, input logic iter);
        int lat;
        int rdy_hi;
        logic [XLEN-1:0] e_res;
        logic e_ill;
        int e_lat;
        e_lat = iter ? XLEN : 0;
`ifdef EXEC_MULDIV_EN
        e_res = exp; e_ill = 1'b0;
`else
        e_res = '0; e_ill = 1'b1; e_lat = 0;
`endif
        out_ready = 1'b1;
        md_drive(op, a, b);
        tick;
        in_valid = 1'b0; md_en = 1'b0;
        lat = 0; rdy_hi = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_hi++;
            tick;
            lat++;
        end
        chk({tag, " latency"}, XLEN'(lat), XLEN'(e_lat));
        chk({tag, " in_ready while busy"}, XLEN'(rdy_hi), 32'd0);
        chk({tag, " out_valid"}, XLEN'(out_valid), 32'd1);
        chk({tag, " result"}, result, e_res);
        chk({tag, " next_pc"}, next_pc, 32'h204);
        chk({tag, " taken"}, XLEN'(taken), 32'd0);
        chk({tag, " illegal"}, XLEN'(illegal), XLEN'(e_ill));
    endtask

    initial begin
        int seen;
        @(posedge clk);
        #1;
        chk("reset out_valid", XLEN'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset next_pc", next_pc, 32'd0);
        chk("reset taken", XLEN'(taken), 32'd0);
        chk("reset illegal", XLEN'(illegal), 32'd0);
        chk("reset in_ready", XLEN'(in_ready), 32'd1);
        rst = 1'b0;

        alu_op(32'h40, 5, 0, 7, 1'b0, 2'b01, 4'b0000, 3'b000, 1'b0);
        tick;
        chk_out("add", 32'd12, 32'h44, 1'b0);
        in_valid = 1'b0;
        tick;
        chk("idle after add", XLEN'(out_valid), 32'd0);

        alu_op(32'h100, 3, 3, 32'h20, 1'b0, 2'b00, 4'b0000, 3'b100, 1'b0);
        tick;
        chk_out("beq", 32'd6, 32'h120, 1'b1);
        alu_op(32'h100, 32'hFFFFFFFF, 1, 32'h20, 1'b0, 2'b00, 4'b1010, 3'b110, 1'b1);
        tick;
        chk_out("bltu", 32'd0, 32'h104, 1'b0);
        alu_op(32'h100, 32'hFFFFFFFF, 1, 32'h20, 1'b0, 2'b00, 4'b0010, 3'b110, 1'b0);
        tick;
        chk_out("blt", 32'd1, 32'h120, 1'b1);
        alu_op(32'h100, 3, 4, 32'h20, 1'b0, 2'b00, 4'b0100, 3'b101, 1'b0);
        tick;
        chk_out("bne", 32'd7, 32'h120, 1'b1);
        alu_op(32'h100, 5, 5, 32'h20, 1'b0, 2'b00, 4'b1111, 3'b111, 1'b0);
        tick;
        chk_out("bge/badctr", 32'd0, 32'h120, 1'b1);
        alu_op(32'h100, 32'h80000000, 4, 0, 1'b0, 2'b00, 4'b1101, 3'b000, 1'b0);
        tick;
        chk_out("sra", 32'hF8000000, 32'h104, 1'b0);
        alu_op(32'h100, 32'h80000000, 4, 0, 1'b0, 2'b00, 4'b0101, 3'b000, 1'b0);
        tick;
        chk_out("srl", 32'h08000000, 32'h104, 1'b0);
        alu_op(32'h100, 1, 33, 0, 1'b0, 2'b00, 4'b0001, 3'b000, 1'b0);
        tick;
        chk_out("sll", 32'd2, 32'h104, 1'b0);
        alu_op(32'h100, 3, 5, 32'h20, 1'b0, 2'b00, 4'b1000, 3'b010, 1'b0);
        tick;
        chk_out("jalr", 32'hFFFFFFFE, 32'h22, 1'b1);
        alu_op(32'h100, 0, 0, 32'h20, 1'b1, 2'b10, 4'b0000, 3'b001, 1'b0);
        tick;
        chk_out("jal", 32'h104, 32'h120, 1'b1);
        alu_op(32'h100, 9, 9, 32'h20, 1'b1, 2'b11, 4'b0000, 3'b011, 1'b0);
        tick;
        chk_out("rsv branch", 32'h100, 32'h104, 1'b0);

        alu_op(0, 32'hF0F0, 32'h0FF0, 0, 1'b0, 2'b00, 4'b0100, 3'b000, 1'b0);
        tick;
        out_ready = 1'b0;
        alu_op(0, 32'hF0F0, 32'h0FF0, 0, 1'b0, 2'b00, 4'b0110, 3'b000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("hold result", result, 32'hFF00);
            chk("hold out_valid", XLEN'(out_valid), 32'd1);
            chk("hold in_ready", XLEN'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", XLEN'(in_ready), 32'd1);
        tick;
        chk_out("or after hold", 32'hFFF0, 32'h4, 1'b0);

        alu_op(0, 1, 1, 0, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0);
        flush = 1'b1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", XLEN'(out_valid), 32'd0);
        chk("flush result kept", result, 32'hFFF0);

        md_case("mulh", 3'b001, 32'h80000000, 2, 32'hFFFFFFFF, 1'b1);
        md_case("mul", 3'b000, 32'hFFFFFFFD, 5, 32'hFFFFFFF1, 1'b1);
        md_case("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1);
        md_case("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        md_case("div by 0", 3'b100, 7, 0, 32'hFFFFFFFF, 1'b0);
        md_case("remu by 0", 3'b111, 5, 0, 32'd5, 1'b0);
        md_case("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0);
        md_case("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        md_case("div neg", 3'b100, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 1'b1);
        md_case("rem neg", 3'b110, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 1'b1);
        md_case("div negb", 3'b100, 20, 32'hFFFFFFFD, 32'hFFFFFFFA, 1'b1);
        md_case("rem negb", 3'b110, 20, 32'hFFFFFFFD, 32'd2, 1'b1);
        md_case("divu", 3'b101, 100, 7, 32'd14, 1'b1);
        md_case("remu", 3'b111, 100, 7, 32'd2, 1'b1);

`ifdef EXEC_MULDIV_EN
        md_drive(3'b101, 100, 7);
        tick;
        in_valid = 1'b0; md_en = 1'b0;
        repeat (10) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick;
        end
        chk("flush calc no out_valid", XLEN'(seen), 32'd0);
        chk("flush calc in_ready", XLEN'(in_ready), 32'd1);
        alu_op(0, 2, 3, 0, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0);
        tick;
        chk_out("add after flush", 32'd5, 32'h4, 1'b0);
        in_valid = 1'b0;

        md_drive(3'b101, 100, 7);
        tick;
        in_valid = 1'b0; md_en = 1'b0;
        repeat (10) tick;
        #2 rst = 1'b1;
        #1;
        chk("rst calc out_valid", XLEN'(out_valid), 32'd0);
        chk("rst calc next_pc", next_pc, 32'd0);
        chk("rst calc in_ready", XLEN'(in_ready), 32'd1);
        tick;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick;
        end
        chk("rst calc no out_valid", XLEN'(seen), 32'd0);
`endif

        alu_op(0, 2, 3, 0, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0);
        tick;
        chk_out("add final", 32'd5, 32'h4, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", XLEN'(out_valid), 32'd0);
        chk("async rst result", result, 32'd0);
        chk("async rst taken", XLEN'(taken), 32'd0);
        tick;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_unit_mc.md
# exec_unit_mc

Multi-cycle, XLEN-parametrised execute stage for the RV32I/M core. It sits between decode and memory/writeback and replaces the purely combinational execute path. Base ALU operations and branch/jump target resolution complete in one cycle. RV32M multiply/divide iterates one bit per cycle. A valid/ready handshake on both sides lets the stage stall decode while an operation is in flight.

## Interface
Parameters:
- XLEN, 32: datapath width; shift amount is the low $clog2(XLEN) bits of B.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  stage can accept an operation this cycle.
- flush  in  1  synchronous abort of any in-flight or held operation.
- pc, rs1, rs2, imm  in  XLEN  operands.
- alua_src  in  1  selects A: 0 = rs1, 1 = pc.
- alub_src  in  2  selects B: 00 = rs2, 01 = imm, 10 = constant 4, 11 = 0.
- alu_ctr  in  4  ALU operation.
- branch  in  3  branch/jump kind.
- br_unsigned  in  1  makes blt/bge compare unsigned (bltu/bgeu).
- md_en  in  1  operation is RV32M; md_op selects the operation and alu_ctr is ignored.
- md_op  in  3  RV32M funct3.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  registered result.
- next_pc  out  XLEN  registered next PC.
- taken  out  1  registered redirect flag.
- illegal  out  1  registered; set when an M op is issued while the M extension is compiled out.

## Operation
ALU operations, selected by alu_ctr:
- 0000 add; 1000 sub; 0111 and; 0110 or; 0100 xor.
- 0011 pass B.
- 0001 sll; 0101 srl; 1101 sra.
- 0010 slt (signed); 1010 sltu.
- Any other code produces 0.

Branch resolution, selected by branch:
- 000: next_pc = pc+4.
- 001 jal: next_pc = pc+imm.
- 010 jalr: next_pc = (rs1+imm) & ~1.
- 100 beq, 101 bne: compare A == B.
- 110 blt, 111 bge: compare A < B, signed unless br_unsigned.
- 011 is reserved and behaves as 000.
- Conditional branches select between pc+imm and pc+4.
- taken = 1 whenever next_pc ≠ pc+4 is selected by a jump or a taken branch.

M operations, selected by md_op:
- 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- Operands are always rs1 and rs2.
- The datapath works on magnitudes and applies sign correction at the end.
- Multiply is shift-add into a 2·XLEN accumulator.
- Divide is restoring, one quotient bit per cycle.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder = 0.
- Both special cases are detected at accept and complete as single-cycle ops.
- An M op produces next_pc = pc+4 and taken = 0.

FSM:
- IDLE: in_ready = 1.
  - A single-cycle op goes to DONE with the result registered.
  - A non-special M op loads operands and goes to CALC.
- CALC: runs an XLEN-count iteration counter.
  - When the counter reaches XLEN−1, the final result is registered and the FSM goes to DONE.
- DONE: out_valid = 1.
  - out_ready with in_valid: the new op is accepted in the same cycle. The FSM re-enters DONE or CALC.
  - out_ready without in_valid: the FSM goes to IDLE.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- flush in any state:
  - The FSM goes to IDLE and out_valid falls the next cycle.
  - Any in_valid in the same cycle is dropped. flush has priority over accept.

## Timing
- Reset (asynchronous): state = IDLE; out_valid, taken and illegal = 0; result, next_pc and the counter = 0.
- Reset mid-CALC abandons the operation with no output.
- Single-cycle op accepted at edge N: out_valid = 1 after edge N.
- Iterative M op accepted at edge N: out_valid = 1 after edge N+XLEN. in_ready stays 0 throughout CALC.
- The outputs and out_valid stay stable while out_valid && !out_ready.
- Back-to-back single-cycle ops with out_ready held at 1 give one result per cycle.

## Configuration
EXEC_MULDIV_EN:
- Defined: the full RV32M path is built and illegal is constant 0.
- Undefined:
  - No CALC state or mul/div hardware is built.
  - An accepted md_en op completes in one cycle with result = 0, next_pc = pc+4, taken = 0, illegal = 1.

## Structure
- Package exec_pkg holds:
  - localparams for the alu_ctr, branch, alub_src and md_op encodings;
  - the FSM state typedef (IDLE, CALC, DONE).
- Sub-module exec_muldiv holds the iterative multiplier/divider: start/busy/done handshake, sign handling and special cases. It is instantiated only under EXEC_MULDIV_EN.

## Test plan
- add, rs1 = 5, imm = 7, alub_src = 01, alu_ctr = 0000 → result = 12 after one cycle; next_pc = pc+4.
- beq, pc = 0x100, rs1 = rs2 = 3, imm = 0x20 → next_pc = 0x120, taken = 1. bltu with rs1 = 0xFFFFFFFF, rs2 = 1 → not taken.
- mulh, rs1 = 0x80000000, rs2 = 2 → result = 0xFFFFFFFF; out_valid exactly 32 cycles after accept; in_ready = 0 while busy.
- div, rs1 = 7, rs2 = 0 → result = 0xFFFFFFFF in one cycle. rem, rs1 = 0x80000000, rs2 = −1 → result = 0.
- Hold out_ready = 0 for 5 cycles after a result → outputs stable, in_ready = 0. Then out_ready = 1 with a new op presented → accepted the same cycle.
- flush or rst asserted at iteration 10 of divu → no out_valid pulse; the next add completes normally.
